// File: rtl/h2bp_decode_stage_pkg.sv
// Shared types, constants and decode functions for the H2BP decode stage.
// The optional illegal-instruction trap (macro H2BP_DECODE_ILLEGAL_EN) uses is_illegal().
package h2bp;

  localparam int INSTR_W = 32;
  localparam int RD_LSB  = 22;
  localparam int RS1_LSB = 17;
  localparam int RS2_LSB = 12;
  localparam int REG_W   = 5;

  // Major opcodes i[31:27] of the memory instructions; they form one contiguous range.
  typedef enum logic [4:0] {
    LW = 5'b11000,
    LH = 5'b11001,
    LB = 5'b11010,
    SW = 5'b11011,
    SH = 5'b11100,
    SB = 5'b11101
  } opcode_e;

  localparam logic [2:0] opSUB     = 3'b001;
  localparam logic [2:0] COND_NONE = 3'b111;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [2:0]       operation;
    logic [31:0]      imm;
    logic             use_alu;
    logic             use_fpu;
    logic             use_imm;
    logic             operand_a_enable;
    logic             operand_b_enable;
    logic             result_enable;
    logic             rd_is_operand_a;
    logic             is_load;
    logic             is_store;
    logic [2:0]       condition;
  } decoded_t;

  localparam decoded_t DEC_NOP = '{
    rd: 5'd0, rs1: 5'd0, rs2: 5'd0, operation: 3'd0, imm: 32'd0,
    use_alu: 1'b0, use_fpu: 1'b0, use_imm: 1'b0,
    operand_a_enable: 1'b1, operand_b_enable: 1'b1,
    result_enable: 1'b0, rd_is_operand_a: 1'b0,
    is_load: 1'b0, is_store: 1'b0, condition: COND_NONE
  };

  function automatic logic is_mem_op(logic [INSTR_W-1:0] i);
    return i[31] && (i[31:27] >= LW) && (i[31:27] <= SB);
  endfunction

  // A branch-class word whose condition field says "never a branch".
  function automatic logic is_illegal(logic [INSTR_W-1:0] i);
    return i[31] && !is_mem_op(i) && (i[29:27] == COND_NONE);
  endfunction

  function automatic decoded_t decode(logic [INSTR_W-1:0] i);
    decoded_t d;
    d     = DEC_NOP;
    d.rd  = i[RD_LSB  +: REG_W];
    d.rs1 = i[RS1_LSB +: REG_W];
    d.rs2 = i[RS2_LSB +: REG_W];
    if (!i[31]) begin
      // Arithmetic: i[26] picks FPU over ALU, i[27] selects the wide immediate form.
      d.operation     = i[30:28];
      d.result_enable = 1'b1;
      d.use_fpu       = i[26];
      d.use_alu       = ~i[26];
      if (!i[27]) begin
        d.imm = {{20{i[11]}}, i[11:0]};
      end else begin
        d.imm = {{16{i[16]}}, i[16:1]};
        if (i[0]) begin
          d.use_imm          = 1'b1;
          d.operand_b_enable = 1'b0;
        end else begin
          d.rd_is_operand_a = 1'b1;
        end
      end
    end else if (is_mem_op(i)) begin
      d.rd_is_operand_a = 1'b1;
      d.result_enable   = 1'b1;
      d.is_load         = (i[31:27] == LW);
      d.is_store        = (i[31:27] == SW);
    end else begin
      // Branch: compare via subtraction, target offset from the wide immediate.
      d.condition       = i[29:27];
      d.use_alu         = 1'b1;
      d.operation       = opSUB;
      d.rd_is_operand_a = 1'b1;
      d.imm             = {{16{i[16]}}, i[16:1]};
    end
    return d;
  endfunction

endpackage

// File: rtl/h2bp_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface h2bp_decode_stage_if #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
);
  import h2bp::*;

  logic                       flush;
  logic                       in_valid;
  logic                       in_ready;
  logic [31:0]                in_instr;
  logic [PC_W-1:0]            in_pc;
  logic                       out_valid;
  logic                       out_ready;
  decoded_t                   out_dec;
  logic [PC_W-1:0]            out_pc;
  logic                       out_illegal;
  logic [$clog2(DEPTH+1)-1:0] count;

  // Surrounding pipeline: drives fetch data, flush and execute ready.
  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_dec, out_pc, out_illegal, count
  );

  // Decode stage view.
  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_dec, out_pc, out_illegal, count
  );
endinterface

// File: rtl/h2bp_decode_stage_fifo.sv
// h2bp_instr_fifo: DEPTH-entry circular buffer with combinational head read.
// Caller guarantees no push when full and no pop when empty.
module h2bp_instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Next pointers/occupancy; power-of-two depth makes pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_i && !pop_i)      count_d = count_q + 1'b1;
      else if (!push_i && pop_i) count_d = count_q - 1'b1;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/h2bp_decode_stage.sv
// H2BP decode stage: instruction buffer feeding a registered decoded_t output.
// Optional: H2BP_DECODE_ILLEGAL_EN flags illegal words and replaces them with DEC_NOP.
module h2bp_decode_stage
  import h2bp::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input logic               clk,
  input logic               rst_n,
  h2bp_decode_stage_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [CNT_W-1:0]     count_w;
  logic [PC_W+31:0]     head_w;
  logic                 push_w, pop_w;
  decoded_t             head_dec_w;
  logic                 head_ill_w;

  logic                 out_valid_q;
  decoded_t             out_dec_q;
  logic [PC_W-1:0]      out_pc_q;
  logic                 out_ill_q;

  // Flush wins over both handshakes; a same-cycle pop does not make room for a push.
  assign bus.in_ready = (count_w < CNT_W'(DEPTH));
  assign push_w = bus.in_valid && bus.in_ready && !bus.flush;
  assign pop_w  = (count_w != '0) && (!out_valid_q || bus.out_ready) && !bus.flush;

  h2bp_instr_fifo #(.DEPTH(DEPTH), .W(PC_W + 32)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (bus.flush),
    .push_i  (push_w),
    .pop_i   (pop_w),
    .wdata_i ({bus.in_pc, bus.in_instr}),
    .rdata_o (head_w),
    .count_o (count_w)
  );

  // Decode the buffer head so it is ready to be captured on a pop.
  always_comb begin
    head_dec_w = decode(head_w[31:0]);
    head_ill_w = 1'b0;
`ifdef H2BP_DECODE_ILLEGAL_EN
    if (is_illegal(head_w[31:0])) begin
      head_ill_w = 1'b1;
      head_dec_w = DEC_NOP;
    end
`endif
  end

  // Output register: load on pop, drop valid once consumed, hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_dec_q   <= DEC_NOP;
      out_pc_q    <= '0;
      out_ill_q   <= 1'b0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
      out_ill_q   <= 1'b0;
    end else if (pop_w) begin
      out_valid_q <= 1'b1;
      out_dec_q   <= head_dec_w;
      out_pc_q    <= head_w[PC_W+31:32];
      out_ill_q   <= head_ill_w;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
      out_ill_q   <= 1'b0;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_dec     = out_dec_q;
  assign bus.out_pc      = out_pc_q;
  assign bus.out_illegal = out_ill_q;
  assign bus.count       = count_w;
endmodule

// File: tb/tb_h2bp_decode_stage.sv
// Scoreboard bench for h2bp_decode_stage; honours H2BP_DECODE_ILLEGAL_EN if defined.
module tb_h2bp_decode_stage;
  import h2bp::*;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  h2bp_decode_stage_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bus();
  h2bp_decode_stage #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    decoded_t        dec;
    logic [PC_W-1:0] pc;
    logic            ill;
  } exp_t;

  exp_t            sb[$];
  int              n_cmp = 0;
  int              n_err = 0;
  logic            rand_ready = 1'b0;
  logic [PC_W-1:0] pc_ctr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Reference decode written from the instruction-format rules.
  function automatic exp_t model(input logic [31:0] w, input logic [PC_W-1:0] pc);
    exp_t e;
    logic [4:0] major;
    logic mem, bad;
    major = w[31:27];
    mem   = (major >= 5'b11000) && (major <= 5'b11101);
    bad   = w[31] && !mem && (w[29:27] == 3'b111);
    e.dec = DEC_NOP;
    e.dec.rd  = w[26:22];
    e.dec.rs1 = w[21:17];
    e.dec.rs2 = w[16:12];
    e.ill = 1'b0;
    e.pc  = pc;
    if (w[31] == 1'b0) begin
      e.dec.operation     = w[30:28];
      e.dec.result_enable = 1'b1;
      e.dec.use_fpu       = w[26];
      e.dec.use_alu       = !w[26];
      e.dec.imm = w[27] ? 32'($signed(w[16:1])) : 32'($signed(w[11:0]));
      if (w[27] && w[0])  begin e.dec.use_imm = 1'b1; e.dec.operand_b_enable = 1'b0; end
      if (w[27] && !w[0]) e.dec.rd_is_operand_a = 1'b1;
    end else if (mem) begin
      e.dec.rd_is_operand_a = 1'b1;
      e.dec.result_enable   = 1'b1;
      e.dec.is_load  = (major == 5'b11000);
      e.dec.is_store = (major == 5'b11011);
    end else begin
      e.dec.condition       = w[29:27];
      e.dec.use_alu         = 1'b1;
      e.dec.operation       = opSUB;
      e.dec.rd_is_operand_a = 1'b1;
      e.dec.imm             = 32'($signed(w[16:1]));
    end
`ifdef H2BP_DECODE_ILLEGAL_EN
    if (bad) begin
      e.dec = DEC_NOP;
      e.ill = 1'b1;
    end
`else
    if (bad) e.ill = 1'b0;
`endif
    return e;
  endfunction

  // Offer one word; expectation is queued on the edge where it is accepted.
  task automatic send(input logic [31:0] w);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_instr = w;
    bus.in_pc    = pc_ctr;
    for (int t = 0; t < 60 && !ok; t++) begin
      @(negedge clk);
      if (bus.in_ready && !bus.flush && rst_n) begin
        sb.push_back(model(w, pc_ctr));
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: got no accept want accept within 60 cycles");
    end
    pc_ctr += 4;
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && sb.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    @(negedge clk);
    sb.delete();
    @(posedge clk); #1;
    bus.flush = 1'b0;
  endtask

  // Pops one expectation per output handshake; also checks stall stability.
  task automatic monitor();
    exp_t     e;
    logic     held;
    decoded_t hd;
    logic [PC_W-1:0] hp;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || bus.flush) begin
        held = 1'b0;
        continue;
      end
      if (held) begin
        chk("hold_valid", 64'(bus.out_valid), 64'd1);
        chk("hold_dec", 64'(bus.out_dec), 64'(hd));
        chk("hold_pc", 64'(bus.out_pc), 64'(hp));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_out: got pc %h want no output", bus.out_pc);
        end else begin
          e = sb.pop_front();
          chk("out_dec", 64'(bus.out_dec), 64'(e.dec));
          chk("out_pc", 64'(bus.out_pc), 64'(e.pc));
          chk("out_illegal", 64'(bus.out_illegal), 64'(e.ill));
          $display("txn pc=%h rd=%0d rs1=%0d rs2=%0d op=%0d imm=%h cond=%0d ill=%0b",
                   bus.out_pc, bus.out_dec.rd, bus.out_dec.rs1, bus.out_dec.rs2,
                   bus.out_dec.operation, bus.out_dec.imm, bus.out_dec.condition, bus.out_illegal);
        end
        held = 1'b0;
      end else if (bus.out_valid) begin
        held = 1'b1;
        hd   = bus.out_dec;
        hp   = bus.out_pc;
      end else begin
        held = 1'b0;
      end
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 3) == 0) w[31:27] = 5'($urandom_range(24, 29));
    return w;
  endfunction

  initial begin
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_out_pc", 64'(bus.out_pc), 64'd0);
    chk("rst_illegal", 64'(bus.out_illegal), 64'd0);
    chk("rst_out_dec", 64'(bus.out_dec), 64'(DEC_NOP));
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    fork
      monitor();
      begin
        forever begin
          @(posedge clk); #2;
          if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
      begin
        // Single word: latency and field values.
        bus.out_ready = 1'b1;
        send(32'h1234_5678);
        @(posedge clk); #1;
        chk("lat_out_valid", 64'(bus.out_valid), 64'd1);
        chk("t1_rd", 64'(bus.out_dec.rd), 64'd8);
        chk("t1_rs1", 64'(bus.out_dec.rs1), 64'd26);
        chk("t1_rs2", 64'(bus.out_dec.rs2), 64'd5);
        chk("t1_op", 64'(bus.out_dec.operation), 64'd1);
        chk("t1_imm", 64'(bus.out_dec.imm), 64'h0000_0678);
        chk("t1_use_alu", 64'(bus.out_dec.use_alu), 64'd1);
        chk("t1_result_en", 64'(bus.out_dec.result_enable), 64'd1);
        drain();

        // Backlog: buffer fills to DEPTH behind a stalled output.
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) send(rand_word());
        chk("full_count", 64'(bus.count), 64'd4);
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        chk("full_out_valid", 64'(bus.out_valid), 64'd1);
        fork
          send(rand_word());
          begin
            repeat (3) @(posedge clk);
            #1;
            chk("stall_count", 64'(bus.count), 64'd4);
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
            bus.out_ready = 1'b1;
          end
        join
        drain();

        // Streaming: one result per cycle, occupancy stays at most 1.
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
          send(rand_word());
          chk("stream_count_le1", 64'(bus.count <= 1), 64'd1);
          if (k > 0) chk("stream_out_valid", 64'(bus.out_valid), 64'd1);
        end
        drain();

        // Branch with negative offset.
        send({5'b10010, 10'h2A5, 16'hFFFE, 1'b1});
        @(posedge clk); #1;
        chk("br_cond", 64'(bus.out_dec.condition), 64'd2);
        chk("br_op", 64'(bus.out_dec.operation), 64'(opSUB));
        chk("br_imm", 64'(bus.out_dec.imm), 64'hFFFF_FFFE);
        drain();

        // Flush with a full-ish buffer and a competing push.
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) send(rand_word());
        chk("pre_flush_count", 64'(bus.count), 64'd3);
        chk("pre_flush_valid", 64'(bus.out_valid), 64'd1);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_instr = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
        sb.delete();
        @(posedge clk); #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("post_flush_count", 64'(bus.count), 64'd0);
        chk("post_flush_valid", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Illegal-class word.
        send(32'hBFFF_FFFF);
        @(posedge clk); #1;
`ifdef H2BP_DECODE_ILLEGAL_EN
        chk("ill_flag", 64'(bus.out_illegal), 64'd1);
        chk("ill_dec_nop", 64'(bus.out_dec), 64'(DEC_NOP));
`else
        chk("ill_flag", 64'(bus.out_illegal), 64'd0);
        chk("ill_cond", 64'(bus.out_dec.condition), 64'd7);
`endif
        drain();

        // Asynchronous reset in mid-operation.
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) send(rand_word());
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 64'(bus.count), 64'd0);
        chk("arst_valid", 64'(bus.out_valid), 64'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic with random back-pressure and occasional flushes.
        rand_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
          case ($urandom_range(0, 19))
            0, 1, 2: begin @(posedge clk); #1; end
            3:       do_flush();
            default: send(rand_word());
          endcase
        end
        rand_ready    = 1'b0;
        bus.out_ready = 1'b1;
        drain();
        repeat (3) @(posedge clk);
        #1;
      end
    join_any
    disable fork;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
